// File: rtl/inv_shift_rows_stream.sv
// inv_shift_rows_stream: collects four 32-bit column beats into an AES
// state, applies (Inv)ShiftRows and holds the result in a registered
// valid/ready output slot. Beats 0-2 sit in a capture buffer; beat 3 is
// combined with the buffer directly on its accepting edge.
// Optional macro ISR_FLUSH_EN adds a 'flush' input that drops a partial block.
module inv_shift_rows_stream #(
    parameter int unsigned INVERSE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [0:31]    in_col,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [0:127]   out_block,
`ifdef ISR_FLUSH_EN
    input  logic           flush,
`endif
    output logic           busy
);

    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [0:95]  cap_q, cap_d;
    logic         out_valid_q, out_valid_d;
    logic [0:127] out_block_q, out_block_d;
    logic [0:127] full_block;
    logic [0:127] perm_block;
    logic         flush_i;
    logic         accept;

`ifdef ISR_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Only the closing beat can stall, and only on a full slot that is not draining
    assign in_ready  = rst_n && !flush_i &&
                       !((col_cnt_q == 2'd3) && out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (col_cnt_q != 2'd0);
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;

    // Row permutation of the buffered columns plus the live closing beat
    always_comb begin
        full_block = {cap_q, in_col};
        perm_block = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (INVERSE != 0) begin
                    perm_block[8*(r+4*c) +: 8] = full_block[8*(r+4*((c+4-r)%4)) +: 8];
                end else begin
                    perm_block[8*(r+4*c) +: 8] = full_block[8*(r+4*((c+r)%4)) +: 8];
                end
            end
        end
    end

    // Beat capture, column counting and output slot load/drain
    always_comb begin
        col_cnt_d   = col_cnt_q;
        cap_d       = cap_q;
        out_valid_d = out_valid_q;
        out_block_d = out_block_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush_i) begin
            col_cnt_d = '0;
            cap_d     = '0;
        end else if (accept) begin
            case (col_cnt_q)
                2'd0:    cap_d[0:31]  = in_col;
                2'd1:    cap_d[32:63] = in_col;
                2'd2:    cap_d[64:95] = in_col;
                default: begin
                    // a load on the same edge as a drain keeps the slot valid
                    out_block_d = perm_block;
                    out_valid_d = 1'b1;
                end
            endcase
            col_cnt_d = col_cnt_q + 2'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt_q   <= '0;
            cap_q       <= '0;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            cap_q       <= cap_d;
            out_valid_q <= out_valid_d;
            out_block_q <= out_block_d;
        end
    end

endmodule

// File: doc/inv_shift_rows_stream.md
Name: inv_shift_rows_stream

Overview:
- Decryption-side counterpart of the encryption ShiftRows stage.
- Accepts an AES state as four 32-bit column beats on a valid/ready stream and assembles the 128-bit block.
- Applies InvShiftRows and presents the result on a registered valid/ready output slot.
- Sits between the round-key/column feed and the InvSubBytes stage of the decryption round pipeline.

Parameters:
- INVERSE, 1: 1 = InvShiftRows (decrypt); 0 = forward ShiftRows (so the same block serves a serial encrypt path).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  column beat valid.
- in_ready  output  1  column beat accepted when in_valid && in_ready.
- in_col  input  [0:31]  one state column; in_col[0:7] = row 0 … in_col[24:31] = row 3.
- out_valid  output  1  out_block holds a permuted block.
- out_ready  input  1  downstream accepts block when out_valid && out_ready.
- out_block  output  [0:127]  permuted state, byte i at bits [8i:8i+7], byte index = 4*col + row.
- busy  output  1  partial block captured (col_cnt != 0).

Behaviour:
- Beat order: beat c (c = 0..3) carries state bytes 4c..4c+3. A 2-bit col_cnt counts accepted beats and wraps 3 -> 0.
- Beats 0-2 are stored in a 96-bit capture buffer. Beat 3 is not stored; it is combined directly with the buffer.
- Permutation, with r = row and c = column:
  - INVERSE=1: out byte (r + 4c) = in byte (r + 4((c - r) mod 4)).
  - INVERSE=0: out byte (r + 4c) = in byte (r + 4((c + r) mod 4)).
  - Row 0 (bytes 0, 4, 8, 12) always passes through unchanged.
- Output slot load: on accepting beat 3, the permuted block is loaded into out_block and out_valid <= 1 on that edge. Latency: out_valid is high in the cycle after the 4th beat handshake.
- Output slot clear: out_valid <= 0 on out_valid && out_ready, unless a new block loads on the same edge, in which case out_valid stays 1.
- in_ready = rst_n && !(col_cnt == 3 && out_valid && !out_ready).
  - Beats 0-2 are always accepted, so the next block is collected while the output waits.
  - Only the closing beat stalls on a full, non-draining slot.
  - in_ready depends combinationally on out_ready; out_valid and out_block are registered only.
- Throughput: one block per 4 cycles with in_valid and out_ready held high; no bubble.
- out_block holds its value while out_valid && !out_ready. Its value after a drain is don't-care, but it must not change until the next load.
- in_col is ignored when !in_valid or !in_ready.
- Reset (rst_n low at an edge): col_cnt = 0, capture buffer = 0, out_valid = 0, out_block = 0, busy = 0. in_ready is 0 while rst_n is low.
- Reset mid-block discards the partial block and any pending output. The first beat after reset is beat 0.

Optional Feature:
- Macro ISR_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush high at an edge clears col_cnt and the capture buffer; busy = 0 next cycle.
  - flush does not touch out_valid or out_block; a pending output still drains normally.
  - in_ready is forced 0 while flush is high, so a beat presented alongside flush is not accepted.
  - rst_n low has priority over flush.
- Undefined:
  - Port flush is absent.
  - A partial block is discarded only by reset.

Test Plan:
- INVERSE=1, out_ready=1, beats 00010203, 04050607, 08090A0B, 0C0D0E0F on consecutive cycles -> out_valid one cycle after beat 3; out_block = 000D0A07 04010E0B 0805020F 0C090603.
- INVERSE=0, same stimulus -> out_block = 00050A0F 04090E03 080D0207 0C01060B.
- Back-to-back blocks with out_ready=0 after the first:
  - Second block beats 0-2 accepted.
  - in_ready=0 at beat 3; first block held stable.
  - Raise out_ready -> beat 3 accepted on that same edge; out_valid stays 1 with the second block.
- Continuous in_valid and out_ready=1 for 3 blocks (12 beats) -> 3 outputs spaced exactly 4 cycles apart; in_ready never drops.
- rst_n low for 1 cycle after 2 beats of a block -> busy=0, out_valid=0, out_block=0. The next 4 beats form a correct block.
- ISR_FLUSH_EN: flush after 2 beats while a previous block is pending -> pending block still delivered unchanged; the next 4 beats produce the correct block; a beat presented during flush is dropped (in_ready=0).
